// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the control unit,
// instruction fetch and the debug/loader port; one transaction in flight, with timeout.
module mem_port_arbiter #(
   parameter int WORD_SIZE      = 8,
   parameter int NUM_REQ        = 3,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ-1:0]           we,
   input  logic [NUM_REQ*WORD_SIZE-1:0] addr,
   input  logic [NUM_REQ*WORD_SIZE-1:0] wdata,
   output logic [NUM_REQ-1:0]           gnt,
   output logic [NUM_REQ-1:0]           rsp_valid,
   output logic [WORD_SIZE-1:0]         rsp_rdata,
   output logic                         rsp_err,
   output logic                         mem_req,
   output logic                         mem_we,
   output logic [WORD_SIZE-1:0]         mem_addr,
   output logic [WORD_SIZE-1:0]         mem_wdata,
   input  logic [WORD_SIZE-1:0]         mem_rdata,
   input  logic                         mem_ack,
   output logic                         busy
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t                 state;
   logic [1:0]             ptr;
   logic [1:0]             owner;
   logic [CNT_W-1:0]       cnt;

   logic [1:0]             win;
   logic [1:0]             ptr_nxt;
   logic                   win_we;
   logic [WORD_SIZE-1:0]   win_addr;
   logic [WORD_SIZE-1:0]   win_wdata;

   // First set request scanning ptr, ptr+1, ptr+2 (mod NUM_REQ); the descending
   // loop lets the closest position to ptr overwrite the farther ones.
   function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [1:0] p);
      logic [1:0] sel;
      logic [2:0] pos;
      sel = p;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         pos = {1'b0, p} + 3'(k);
         if (pos >= 3'(NUM_REQ)) pos = pos - 3'(NUM_REQ);
         if (r[pos[1:0]]) sel = pos[1:0];
      end
      return sel;
   endfunction

   always_comb begin
      win       = rr_pick(req, ptr);
      ptr_nxt   = (win == 2'(NUM_REQ - 1)) ? 2'd0 : win + 2'd1;
      win_we    = we[win];
      win_addr  = addr[int'(win)*WORD_SIZE +: WORD_SIZE];
      win_wdata = wdata[int'(win)*WORD_SIZE +: WORD_SIZE];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         ptr       <= 2'd0;
         owner     <= 2'd0;
         cnt       <= '0;
         gnt       <= '0;
         rsp_valid <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         busy      <= 1'b0;
      end else begin
         gnt       <= '0;
         rsp_valid <= '0;
         rsp_err   <= 1'b0;
         case (state)
            IDLE: begin
               // A late mem_ack here belongs to a dropped transaction and is ignored.
               if (|req) begin
                  state     <= BUSY;
                  owner     <= win;
                  ptr       <= ptr_nxt;
                  cnt       <= '0;
                  gnt       <= NUM_REQ'(1) << win;
                  mem_req   <= 1'b1;
                  busy      <= 1'b1;
                  mem_we    <= win_we;
                  mem_addr  <= win_addr;
                  mem_wdata <= win_wdata;
               end
            end
            BUSY: begin
               if (mem_ack) begin
                  state     <= IDLE;
                  rsp_valid <= NUM_REQ'(1) << owner;
                  rsp_rdata <= mem_rdata;
                  mem_req   <= 1'b0;
                  busy      <= 1'b0;
               end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  // This edge closes the last allowed BUSY cycle without an ack.
                  state     <= IDLE;
                  rsp_valid <= NUM_REQ'(1) << owner;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b1;
                  mem_req   <= 1'b0;
                  busy      <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
